// File: rtl/lut5_cfg_writer.sv
// lut5_cfg_writer
//   Runtime-reconfigurable 5-input LUT with a serial configuration writer. A 32-bit
//   truth-table word is accepted over valid/ready and shifted MSB-first into the LUT
//   contents register, BITS_PER_CYCLE bits per clock, like a LUT configuration chain.
//
// Parameters
//   INIT            LUT contents after reset
//   BITS_PER_CYCLE  bits shifted per cycle (1, 2, 4, 8, 16 or 32); 32/BITS_PER_CYCLE
//                   shift cycles per load
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   cfg_data_i   new truth table, bit k = output for address k
//   cfg_valid_i  cfg_data_i valid
//   cfg_ready_o  writer can accept a word (IDLE or DONE)
//   cfg_busy_o   shift in progress
//   cfg_done_o   one-cycle pulse, load complete
//   adr0_i..adr4_i  LUT address, adr4_i is the MSB
//   o_o          LUT output (live, shows partial contents while busy)
//   cdo_o        cascade out, contents bit 31
//   rb_data_o    (LUT5_CFG_READBACK_EN only) contents displaced by the last load
//   rb_valid_o   (LUT5_CFG_READBACK_EN only) high in the DONE cycle
//
// Optional feature macro: LUT5_CFG_READBACK_EN
module lut5_cfg_writer #(
    parameter logic [31:0] INIT           = 32'h0000_0000,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] cfg_data_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    output logic        cfg_busy_o,
    output logic        cfg_done_o,
    input  logic        adr0_i,
    input  logic        adr1_i,
    input  logic        adr2_i,
    input  logic        adr3_i,
    input  logic        adr4_i,
    output logic        o_o,
    output logic        cdo_o
`ifdef LUT5_CFG_READBACK_EN
    ,
    output logic [31:0] rb_data_o,
    output logic        rb_valid_o
`endif
);

    localparam int unsigned B         = BITS_PER_CYCLE;
    localparam int unsigned NumShifts = 32 / B;

    if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16 || B == 32)) begin : gen_bad_bpc
        $error("lut5_cfg_writer: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] lut_q, lut_d;
    logic [31:0] stage_q, stage_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        last_shift;
    logic [4:0]  adr;

`ifdef LUT5_CFG_READBACK_EN
    logic [31:0] rb_shift_q, rb_shift_d;
    logic [31:0] rb_data_q, rb_data_d;
`endif

    assign last_shift = (cnt_q == 6'(NumShifts - 1));

    always_comb begin
        state_d = state_q;
        lut_d   = lut_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
`ifdef LUT5_CFG_READBACK_EN
        rb_shift_d = rb_shift_q;
        rb_data_d  = rb_data_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    state_d = StIdle;
                end
                if (cfg_valid_i) begin
                    stage_d = cfg_data_i;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Top B bits of the staged word enter at the bottom of the LUT.
                lut_d   = (lut_q << B) | (stage_q >> (32 - B));
                stage_d = stage_q << B;
                cnt_d   = cnt_q + 6'd1;
`ifdef LUT5_CFG_READBACK_EN
                // Collect the displaced top bits; after N shifts this is the old word.
                rb_shift_d = (rb_shift_q << B) | (lut_q >> (32 - B));
                if (last_shift) begin
                    rb_data_d = rb_shift_d;
                end
`endif
                if (last_shift) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            lut_q   <= INIT;
            stage_q <= '0;
            cnt_q   <= '0;
`ifdef LUT5_CFG_READBACK_EN
            rb_shift_q <= '0;
            rb_data_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lut_q   <= lut_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
`ifdef LUT5_CFG_READBACK_EN
            rb_shift_q <= rb_shift_d;
            rb_data_q  <= rb_data_d;
`endif
        end
    end

    assign cfg_ready_o = (state_q == StIdle) || (state_q == StDone);
    assign cfg_busy_o  = (state_q == StShift);
    assign cfg_done_o  = (state_q == StDone);

    assign adr   = {adr4_i, adr3_i, adr2_i, adr1_i, adr0_i};
    assign o_o   = lut_q[adr];
    assign cdo_o = lut_q[31];

`ifdef LUT5_CFG_READBACK_EN
    assign rb_data_o  = rb_data_q;
    assign rb_valid_o = (state_q == StDone);
`endif

endmodule

// File: tb/tb_lut5_cfg_writer.sv
// Bench for lut5_cfg_writer: one instance with BITS_PER_CYCLE=1 and one with 4.
// Loads are pushed to a per-instance scoreboard on the accept edge and checked against
// an address sweep of the LUT when CFG_DONE appears.
module tb_lut5_cfg_writer;

    localparam logic [31:0] Init0 = 32'hDEAD_BEEF;
    localparam logic [31:0] Init1 = 32'h0F0F_0F0F;

    logic        clk;
    logic        rst_s   [2];
    logic [31:0] data_s  [2];
    logic        valid_s [2];
    logic        ready_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [4:0]  adr_s   [2];
    logic        o_s     [2];
    logic        cdo_s   [2];
`ifdef LUT5_CFG_READBACK_EN
    logic [31:0] rb_data_s  [2];
    logic        rb_valid_s [2];
`endif

    int chk = 0;
    int err = 0;

    logic [31:0] sb0[$];
    logic [31:0] sb1[$];

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic [4:0]  adr;
        logic        exp_o;
        logic        exp_cdo;
        int          exp_n;
    } vec_t;

    vec_t vecs[9];

    lut5_cfg_writer #(.INIT(Init0), .BITS_PER_CYCLE(1)) u_b1 (
        .clk_i      (clk),
        .rst_i      (rst_s[0]),
        .cfg_data_i (data_s[0]),
        .cfg_valid_i(valid_s[0]),
        .cfg_ready_o(ready_s[0]),
        .cfg_busy_o (busy_s[0]),
        .cfg_done_o (done_s[0]),
        .adr0_i     (adr_s[0][0]),
        .adr1_i     (adr_s[0][1]),
        .adr2_i     (adr_s[0][2]),
        .adr3_i     (adr_s[0][3]),
        .adr4_i     (adr_s[0][4]),
        .o_o        (o_s[0]),
        .cdo_o      (cdo_s[0])
`ifdef LUT5_CFG_READBACK_EN
        ,
        .rb_data_o  (rb_data_s[0]),
        .rb_valid_o (rb_valid_s[0])
`endif
    );

    lut5_cfg_writer #(.INIT(Init1), .BITS_PER_CYCLE(4)) u_b4 (
        .clk_i      (clk),
        .rst_i      (rst_s[1]),
        .cfg_data_i (data_s[1]),
        .cfg_valid_i(valid_s[1]),
        .cfg_ready_o(ready_s[1]),
        .cfg_busy_o (busy_s[1]),
        .cfg_done_o (done_s[1]),
        .adr0_i     (adr_s[1][0]),
        .adr1_i     (adr_s[1][1]),
        .adr2_i     (adr_s[1][2]),
        .adr3_i     (adr_s[1][3]),
        .adr4_i     (adr_s[1][4]),
        .o_o        (o_s[1]),
        .cdo_o      (cdo_s[1])
`ifdef LUT5_CFG_READBACK_EN
        ,
        .rb_data_o  (rb_data_s[1]),
        .rb_valid_o (rb_valid_s[1])
`endif
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Sweep all 32 addresses; 32 time units, well inside half a clock period.
    task automatic read_lut(input int sel, output logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            adr_s[sel] = 5'(i);
            #1;
            w[i] = o_s[sel];
        end
    endtask

    task automatic accept(input int sel, input logic [31:0] d);
        for (int i = 0; i < 300; i++) begin
            if (ready_s[sel]) break;
            @(posedge clk);
            #1;
        end
        check("accept ready", 32'(ready_s[sel]), 32'd1);
        data_s[sel]  = d;
        valid_s[sel] = 1'b1;
        @(posedge clk);
        #1;
        valid_s[sel] = 1'b0;
        if (sel == 0) sb0.push_back(d);
        else          sb1.push_back(d);
    endtask

    // Called just after an accept edge; returns still inside the DONE cycle.
    task automatic wait_done(input int sel, input int exp_n, input string name);
        int          n;
        int          bcnt;
        int          rdy_hi;
        int          qsz;
        logic [31:0] w;
        logic [31:0] e;
        n      = 0;
        bcnt   = int'(busy_s[sel]);
        rdy_hi = int'(ready_s[sel]);
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (done_s[sel]) begin
                n = i;
                break;
            end
            bcnt   += int'(busy_s[sel]);
            rdy_hi += int'(ready_s[sel]);
        end
        check({name, " done latency"}, 32'(n), 32'(exp_n));
        check({name, " busy cycles"}, 32'(bcnt), 32'(exp_n));
        check({name, " ready while busy"}, 32'(rdy_hi), 32'd0);
        if (n != 0) begin
            check({name, " busy in done"}, 32'(busy_s[sel]), 32'd0);
            check({name, " ready in done"}, 32'(ready_s[sel]), 32'd1);
            qsz = (sel == 0) ? sb0.size() : sb1.size();
            check({name, " scoreboard depth"}, 32'(qsz), 32'd1);
            if (qsz > 0) begin
                if (sel == 0) e = sb0.pop_front();
                else          e = sb1.pop_front();
                read_lut(sel, w);
                check({name, " contents"}, w, e);
                check({name, " cdo"}, 32'(cdo_s[sel]), 32'(e[31]));
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] loaded[2];
        int          s;
        int          dcnt;

        vecs[0] = '{0, 32'h8000_0001, 5'd31, 1'b1, 1'b1, 32};
        vecs[1] = '{0, 32'h8000_0001, 5'd0,  1'b1, 1'b1, 32};
        vecs[2] = '{0, 32'h8000_0001, 5'd1,  1'b0, 1'b1, 32};
        vecs[3] = '{0, 32'h8000_0001, 5'd30, 1'b0, 1'b1, 32};
        vecs[4] = '{1, 32'h1234_5678, 5'd0,  1'b0, 1'b0, 8};
        vecs[5] = '{1, 32'h1234_5678, 5'd3,  1'b1, 1'b0, 8};
        vecs[6] = '{1, 32'h1234_5678, 5'd4,  1'b1, 1'b0, 8};
        vecs[7] = '{1, 32'h1234_5678, 5'd28, 1'b1, 1'b0, 8};
        vecs[8] = '{1, 32'h1234_5678, 5'd31, 1'b0, 1'b0, 8};

        for (int i = 0; i < 2; i++) begin
            rst_s[i]   = 1'b1;
            valid_s[i] = 1'b0;
            data_s[i]  = '0;
            adr_s[i]   = '0;
        end
        loaded[0] = Init0;
        loaded[1] = Init1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        check("rst ready", 32'(ready_s[0]), 32'd1);
        check("rst busy", 32'(busy_s[0]), 32'd0);
        check("rst done", 32'(done_s[0]), 32'd0);
        adr_s[0] = 5'd0;
        #1;
        check("rst o adr0", 32'(o_s[0]), 32'd1);
        adr_s[0] = 5'd4;
        #1;
        check("rst o adr4", 32'(o_s[0]), 32'd0);
        check("rst cdo", 32'(cdo_s[0]), 32'd1);
        read_lut(1, w);
        check("rst b4 contents", w, 32'h0F0F_0F0F);

        // Table-driven loads and address checks
        for (int k = 0; k < 9; k++) begin
            s = vecs[k].sel;
            if (vecs[k].data !== loaded[s]) begin
                accept(s, vecs[k].data);
                wait_done(s, vecs[k].exp_n, $sformatf("vec%0d load", k));
                loaded[s] = vecs[k].data;
            end
            adr_s[s] = vecs[k].adr;
            #1;
            check($sformatf("vec%0d o", k), 32'(o_s[s]), 32'(vecs[k].exp_o));
            check($sformatf("vec%0d cdo", k), 32'(cdo_s[s]), 32'(vecs[k].exp_cdo));
        end

        // Word offered while busy is held off, then taken in the DONE cycle
        accept(0, 32'h5A5A_0F0F);
        data_s[0]  = 32'hFFFF_FFFF;
        valid_s[0] = 1'b1;
        wait_done(0, 32, "held first");
        sb0.push_back(32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        valid_s[0] = 1'b0;
        check("held accepted busy", 32'(busy_s[0]), 32'd1);
        check("held accepted done low", 32'(done_s[0]), 32'd0);
        wait_done(0, 32, "held second");

        // Back-to-back on the 4-bit instance
        accept(1, 32'hA5C3_0001);
        data_s[1]  = 32'hCAFE_F00D;
        valid_s[1] = 1'b1;
        wait_done(1, 8, "b2b first");
        sb1.push_back(32'hCAFE_F00D);
        @(posedge clk);
        #1;
        valid_s[1] = 1'b0;
        check("b2b accepted busy", 32'(busy_s[1]), 32'd1);
        wait_done(1, 8, "b2b second");

        // Reset after 10 shift edges discards the partial load
        accept(0, 32'h1234_5678);
        repeat (10) @(posedge clk);
        #1;
        rst_s[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        sb0.delete();
        check("midrst ready", 32'(ready_s[0]), 32'd1);
        check("midrst busy", 32'(busy_s[0]), 32'd0);
        read_lut(0, w);
        check("midrst contents", w, Init0);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            dcnt += int'(done_s[0]);
        end
        check("midrst no done", 32'(dcnt), 32'd0);

`ifdef LUT5_CFG_READBACK_EN
        check("rb reset valid", 32'(rb_valid_s[0]), 32'd0);
        check("rb reset data", rb_data_s[0], 32'd0);
        accept(0, 32'h0000_0000);
        wait_done(0, 32, "readback");
        check("rb valid in done", 32'(rb_valid_s[0]), 32'd1);
        check("rb data", rb_data_s[0], 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("rb valid after", 32'(rb_valid_s[0]), 32'd0);
        check("rb data hold", rb_data_s[0], 32'hDEAD_BEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
